axis_sync_fifo: RTL and testbench

Single-clock AXI4-Stream FIFO with a registered output stage. The packet allocator uses it as a free-list queue of buffer addresses: it is preloaded with DEPTH slot addresses after reset, popped on packet allocation and refilled on feedback. The block also serves as a generic stream buffer, with optional tkeep/tlast/tuser sideband.

---
 rtl/axis_sync_fifo.sv | 135 +++++++++++++
 tb/tb_axis_sync_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
// Single-clock AXI4-Stream FIFO built from a DEPTH-entry RAM and one output
// register. Used as the allocator's free-list of buffer addresses and as a
// generic stream buffer with optional tkeep/tlast/tuser sideband.
//
// Ports:
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   s_axis_*             input stream (tdata/tkeep/tlast/tuser/tvalid/tready)
//   m_axis_*             output stream (tdata/tkeep/tlast/tuser/tvalid/tready)
//   count                words held, RAM plus output register
module axis_sync_fifo #(
  parameter int DEPTH       = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = 0,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE = 0,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]            r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_s_ready;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [KEEP_WIDTH-1:0]   r_out_keep;
  logic                    r_out_last;
  logic [USER_WIDTH-1:0]   r_out_user;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_load;
  logic [CW-1:0]           w_ram_words;
  logic [CW-1:0]           w_count_next;
  logic [KEEP_WIDTH-1:0]   w_keep_in;
  logic                    w_last_in;
  logic [USER_WIDTH-1:0]   w_user_in;
  logic [W-1:0]            w_din;
  logic [W-1:0]            w_rd_word;

  assign w_push = s_axis_tvalid && r_s_ready;
  assign w_pop  = r_out_valid && m_axis_tready;

  // Words still sitting in the RAM (the output register is counted in r_count).
  assign w_ram_words = r_count - CW'(r_out_valid);
  assign w_load      = (w_ram_words != '0) && (!r_out_valid || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Disabled sideband is normalised on the way in so the RAM never holds junk.
  assign w_keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign w_last_in = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
  assign w_user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;
  assign w_din     = {s_axis_tdata, w_keep_in, w_last_in, w_user_in};

  // Plain RAM with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  assign w_rd_word = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_s_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_word[W-1 -: DATA_WIDTH];
        r_out_keep  <= w_rd_word[USER_WIDTH+1 +: KEEP_WIDTH];
        r_out_last  <= w_rd_word[USER_WIDTH];
        r_out_user  <= w_rd_word[USER_WIDTH-1:0];
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      r_count <= w_count_next;
      // Rising edge of ready lags a pop by one cycle (registered, no path from
      // m_axis_tready); the next-count term drops it as soon as the FIFO fills.
      r_s_ready <= (r_count < DEPTH_C) && (w_count_next < DEPTH_C);
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? r_out_keep : '1;
  assign m_axis_tlast  = (LAST_ENABLE != 0) ? r_out_last : 1'b1;
  assign m_axis_tuser  = (USER_ENABLE != 0) ? r_out_user : '0;
  assign count         = r_count;

endmodule

// File: tb/tb_axis_sync_fifo.sv
module tb_axis_sync_fifo;

  logic        clk = 1'b0;
  logic        rstn;

  // main instance: DEPTH=4, tlast/tuser carried, tkeep disabled
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic [0:0]  s_user;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [0:0]  m_user;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  cnt;

  // second instance: all sideband disabled
  logic [31:0] p_sdata;
  logic [3:0]  p_skeep;
  logic        p_slast;
  logic [0:0]  p_suser;
  logic        p_svalid;
  logic        p_sready;
  logic [31:0] p_mdata;
  logic [3:0]  p_mkeep;
  logic        p_mlast;
  logic [0:0]  p_muser;
  logic        p_mvalid;
  logic        p_mready;
  logic [2:0]  p_cnt;

  always #5 clk = ~clk;

  axis_sync_fifo #(
    .DEPTH(4), .DATA_WIDTH(32), .KEEP_ENABLE(0), .LAST_ENABLE(1),
    .USER_ENABLE(1), .USER_WIDTH(1)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tuser(m_user), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .count(cnt)
  );

  axis_sync_fifo #(
    .DEPTH(4), .DATA_WIDTH(32), .KEEP_ENABLE(0), .LAST_ENABLE(0),
    .USER_ENABLE(0), .USER_WIDTH(1)
  ) u_plain (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(p_sdata), .s_axis_tkeep(p_skeep), .s_axis_tlast(p_slast),
    .s_axis_tuser(p_suser), .s_axis_tvalid(p_svalid), .s_axis_tready(p_sready),
    .m_axis_tdata(p_mdata), .m_axis_tkeep(p_mkeep), .m_axis_tlast(p_mlast),
    .m_axis_tuser(p_muser), .m_axis_tvalid(p_mvalid), .m_axis_tready(p_mready),
    .count(p_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expected beats: {data, last, user}
  logic [33:0] sb[$];

  int cyc = 0;
  logic stream_phase = 1'b0;
  int   stream_pops  = 0;
  int   first_pop    = 0;
  int   last_pop     = 0;
  int   max_cnt      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat presented with ready high at the negedge is consumed at the next edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (stream_phase && int'(cnt) > max_cnt) max_cnt = int'(cnt);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got data %0h, expected no beat", m_data);
        end else begin
          logic [33:0] e;
          e = sb.pop_front();
          check("pop_data", {32'd0, m_data}, {32'd0, e[33:2]});
          check("pop_last", {63'd0, m_last}, {63'd0, e[1]});
          check("pop_user", {63'd0, m_user}, {63'd0, e[0]});
          check("pop_keep", {60'd0, m_keep}, 64'hF);
        end
        if (stream_phase) begin
          if (stream_pops == 0) first_pop = cyc;
          last_pop = cyc;
          stream_pops++;
        end
      end
    end
  end

  // Drive one beat (call at posedge+#1); returns at posedge+#1 after the accepting edge.
  task automatic push(input logic [31:0] d, input logic l, input logic u);
    logic acc;
    int budget;
    s_data  = d;
    s_last  = l;
    s_user  = u;
    s_valid = 1'b1;
    budget  = 0;
    do begin
      acc = s_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 20);
    s_valid = 1'b0;
    if (acc) sb.push_back({d, l, u});
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: data %0h got no ready, expected ready within 20 cycles", d);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    s_data = '0; s_keep = '0; s_last = 1'b0; s_user = '0; s_valid = 1'b0; m_ready = 1'b0;
    p_sdata = '0; p_skeep = '0; p_slast = 1'b0; p_suser = '0; p_svalid = 1'b0; p_mready = 1'b0;

    // reset then idle
    tick(3);
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_ready", {63'd0, s_ready}, 64'd0);
    check("rst_count", {61'd0, cnt}, 64'd0);
    rstn = 1'b1;
    check("ready_before_edge", {63'd0, s_ready}, 64'd0);
    tick(1);
    check("ready_after_release", {63'd0, s_ready}, 64'd1);

    // latency on empty FIFO
    push(32'h55, 1'b1, 1'b1);
    check("lat_valid_k", {63'd0, m_valid}, 64'd0);
    check("lat_count_k", {61'd0, cnt}, 64'd1);
    tick(1);
    check("lat_valid_k1", {63'd0, m_valid}, 64'd1);
    check("lat_data_k1", {32'd0, m_data}, 64'h55);
    m_ready = 1'b1;
    tick(1);
    check("lat_count_after_pop", {61'd0, cnt}, 64'd0);
    check("lat_valid_after_pop", {63'd0, m_valid}, 64'd0);
    m_ready = 1'b0;

    // fill and drain
    push(32'hA0, 1'b0, 1'b0);
    push(32'hA1, 1'b0, 1'b1);
    push(32'hA2, 1'b1, 1'b0);
    push(32'hA3, 1'b1, 1'b1);
    check("full_count", {61'd0, cnt}, 64'd4);
    check("full_ready", {63'd0, s_ready}, 64'd0);
    s_data = 32'hA4; s_valid = 1'b1;
    tick(3);
    s_valid = 1'b0;
    check("full_count_hold", {61'd0, cnt}, 64'd4);
    m_ready = 1'b1;
    tick(1);
    check("nf_count_after_pop", {61'd0, cnt}, 64'd3);
    check("nf_ready_lag", {63'd0, s_ready}, 64'd0);
    tick(1);
    check("nf_ready_rise", {63'd0, s_ready}, 64'd1);
    tick(5);
    check("drain_count", {61'd0, cnt}, 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // streaming with wrap, no bubbles
    stream_phase = 1'b1;
    for (int i = 0; i < 20; i++) push(32'(i), (i % 4) == 3, i[0]);
    tick(4);
    stream_phase = 1'b0;
    check("stream_pops", 64'(stream_pops), 64'd20);
    check("stream_no_bubble", 64'(last_pop - first_pop), 64'd19);
    check("stream_max_count", 64'(max_cnt), 64'd2);
    m_ready = 1'b0;

    // backpressure: output held stable while more words arrive
    push(32'hB0, 1'b0, 1'b1);
    push(32'hB1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) push(32'hB2, 1'b0, 1'b0);
      else if (i == 1) push(32'hB3, 1'b1, 1'b1);
      else tick(1);
      check("bp_valid", {63'd0, m_valid}, 64'd1);
      check("bp_data", {32'd0, m_data}, 64'hB0);
      check("bp_user", {63'd0, m_user}, 64'd1);
    end
    check("bp_count", {61'd0, cnt}, 64'd4);
    m_ready = 1'b1;
    tick(6);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    m_ready = 1'b0;

    // all sideband disabled
    p_sdata = 32'h77; p_skeep = 4'h0; p_slast = 1'b0; p_suser = 1'b1; p_svalid = 1'b1;
    tick(1);
    p_svalid = 1'b0;
    tick(1);
    check("plain_valid", {63'd0, p_mvalid}, 64'd1);
    check("plain_data", {32'd0, p_mdata}, 64'h77);
    check("plain_keep", {60'd0, p_mkeep}, 64'hF);
    check("plain_last", {63'd0, p_mlast}, 64'd1);
    check("plain_user", {63'd0, p_muser}, 64'd0);

    // reset mid-stream with 3 words queued
    push(32'hC0, 1'b1, 1'b1);
    push(32'hC1, 1'b1, 1'b1);
    push(32'hC2, 1'b1, 1'b1);
    check("pre_rst_count", {61'd0, cnt}, 64'd3);
    rstn = 1'b0;
    sb.delete();
    tick(1);
    check("mid_rst_count", {61'd0, cnt}, 64'd0);
    check("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_data", {32'd0, m_data}, 64'd0);
    check("mid_rst_last", {63'd0, m_last}, 64'd0);
    rstn = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("post_rst_no_stale", {63'd0, m_valid}, 64'd0);
    end
    push(32'hD0, 1'b0, 1'b1);
    tick(3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_count", {61'd0, cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
